// File: rtl/m_mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states and access owner.
package m_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   // States in which a new access may be arbitrated and granted.
   function automatic logic is_arb_state(input state_e s);
      return (s == IDLE) || (s == RESP);
   endfunction

endpackage

// File: rtl/m_arb_prio.sv
// Two-requester fixed-priority arbiter (data first) with a starvation guard for fetch.
module m_arb_prio #(
   parameter int STARVE_MAX = 4
) (
   input  logic w_clk,
   input  logic w_rst,
   input  logic w_arb_en,
   input  logic w_if_req,
   input  logic w_d_req,
   output logic w_if_gnt,
   output logic w_d_gnt
);

   localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             if_forced;

   // Grant selection: data wins unless a waiting fetch has lost STARVE_MAX times in a row.
   always_comb begin
      if_forced = w_if_req && (starve_cnt_q == CNT_MAX);
      w_d_gnt   = w_arb_en && w_d_req && !if_forced;
      w_if_gnt  = w_arb_en && w_if_req && !w_d_gnt;
   end

   // Starvation count: only arbitration cycles move it; saturates at STARVE_MAX.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (w_arb_en) begin
         if (!w_if_req || w_if_gnt) begin
            starve_cnt_d = '0;
         end else if (starve_cnt_q != CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
         end
      end
   end

   // Starvation counter register.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/m_mem_arb.sv
// Single-outstanding arbiter/sequencer for a unified memory shared by the fetch and data ports.
module m_mem_arb
   import m_mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              w_clk,
   input  logic              w_rst,
   input  logic              w_if_req,
   input  logic [ADDR_W-1:0] w_if_addr,
   output logic              w_if_gnt,
   output logic              w_if_rvalid,
   output logic [DATA_W-1:0] w_if_rdata,
   input  logic              w_d_req,
   input  logic              w_d_we,
   input  logic [ADDR_W-1:0] w_d_addr,
   input  logic [DATA_W-1:0] w_d_wdata,
   output logic              w_d_gnt,
   output logic              w_d_rvalid,
   output logic [DATA_W-1:0] w_d_rdata,
   output logic              w_m_en,
   output logic              w_m_we,
   output logic [ADDR_W-1:0] w_m_addr,
   output logic [DATA_W-1:0] w_m_wdata,
   input  logic              w_m_ack,
   input  logic [DATA_W-1:0] w_m_rdata
);

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic                cmd_we_q, cmd_we_d;
   logic                m_en_q, m_en_d;
   logic                m_we_q, m_we_d;
   logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
   logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                arb_en;

   m_arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_arb (
      .w_clk    (w_clk),
      .w_rst    (w_rst),
      .w_arb_en (arb_en),
      .w_if_req (w_if_req),
      .w_d_req  (w_d_req),
      .w_if_gnt (w_if_gnt),
      .w_d_gnt  (w_d_gnt)
   );

   // FSM state register.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: ack is only honoured in WAIT, so early or stray acks are dropped.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, RESP: state_d = (w_if_gnt || w_d_gnt) ? ISSUE : IDLE;
         ISSUE:      state_d = WAIT;
         WAIT:       if (w_m_ack) state_d = RESP;
         default:    state_d = IDLE;
      endcase
   end

   // FSM outputs: arbitration window (never during reset) and owner-routed response.
   always_comb begin
      arb_en      = is_arb_state(state_q) && !w_rst;
      w_if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
      w_d_rvalid  = (state_q == RESP) && (owner_q == OWN_D);
      w_if_rdata  = w_if_rvalid ? rdata_q : '0;
      w_d_rdata   = w_d_rvalid  ? rdata_q : '0;
   end

   // Command latch on grant, one-cycle memory strobe, and read-data capture in WAIT.
   always_comb begin
      owner_d   = owner_q;
      cmd_we_d  = cmd_we_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      rdata_d   = rdata_q;
      m_en_d    = 1'b0;
      m_we_d    = 1'b0;
      if (w_d_gnt) begin
         owner_d   = OWN_D;
         cmd_we_d  = w_d_we;
         m_en_d    = 1'b1;
         m_we_d    = w_d_we;
         m_addr_d  = w_d_addr;
         m_wdata_d = w_d_wdata;
      end else if (w_if_gnt) begin
         owner_d  = OWN_IF;
         cmd_we_d = 1'b0;
         m_en_d   = 1'b1;
         m_addr_d = w_if_addr;
      end
      if ((state_q == WAIT) && w_m_ack) begin
         rdata_d = cmd_we_q ? '0 : w_m_rdata;
      end
   end

   // Datapath registers.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         owner_q   <= OWN_IF;
         cmd_we_q  <= 1'b0;
         m_en_q    <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         rdata_q   <= '0;
      end else begin
         owner_q   <= owner_d;
         cmd_we_q  <= cmd_we_d;
         m_en_q    <= m_en_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         rdata_q   <= rdata_d;
      end
   end

   assign w_m_en    = m_en_q;
   assign w_m_we    = m_we_q;
   assign w_m_addr  = m_addr_q;
   assign w_m_wdata = m_wdata_q;

endmodule
